// File: rtl/synchronous_fifo_flags_if.sv
// Handshake and status bundle for the single-clock flagged FIFO.
// The FIFO takes the slave side and the producer/consumer takes the master side.
interface synchronous_fifo_flags_if #(
  parameter int G_WIDTH = 8,
  parameter int G_DEPTH = 4
);
  logic               i_clr;
  logic               i_wr;
  logic [G_WIDTH-1:0] i_data;
  logic               i_rd;
  logic [G_WIDTH-1:0] o_data;
  logic               o_valid;
  logic               o_full;
  logic               o_empty;
  logic               o_almost_full;
  logic               o_almost_empty;
  logic [G_DEPTH:0]   o_fill;
  logic               o_overflow;
  logic               o_underflow;

  modport slave (
    input  i_clr, i_wr, i_data, i_rd,
    output o_data, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
           o_fill, o_overflow, o_underflow
  );

  modport master (
    output i_clr, i_wr, i_data, i_rd,
    input  o_data, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
           o_fill, o_overflow, o_underflow
  );
endinterface

// File: rtl/synchronous_fifo_flags.sv
// Single-clock FIFO with a registered fill counter, threshold flags, flush and
// overflow/underflow pulses; standard registered-read or first-word-fall-through.
module synchronous_fifo_flags #(
  parameter int G_WIDTH  = 8,
  parameter int G_DEPTH  = 4,
  parameter int G_FWFT   = 0,
  parameter int G_AFULL  = 12,
  parameter int G_AEMPTY = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  synchronous_fifo_flags_if.slave bus
);
  localparam int               PW        = G_DEPTH + 1;
  localparam logic [PW-1:0]    ONE       = PW'(1);
  localparam logic [PW-1:0]    NWORDS    = PW'(2 ** G_DEPTH);
  localparam logic [PW-1:0]    AFULL_TH  = PW'(G_AFULL);
  localparam logic [PW-1:0]    AEMPTY_TH = PW'(G_AEMPTY);

  logic [G_WIDTH-1:0] mem_q [2**G_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill_q, fill_d;
  logic               full_q, full_d, empty_q, empty_d;
  logic               afull_q, afull_d, aempty_q, aempty_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;
  logic               rd_ok, wr_ok;
  logic [G_WIDTH-1:0] head;

  always_comb begin
    rd_ok    = bus.i_rd && !empty_q && !bus.i_clr;
    // A read in the same cycle frees the slot a write into a full FIFO needs.
    wr_ok    = bus.i_wr && (!full_q || rd_ok) && !bus.i_clr;
    ovf_d    = bus.i_wr && !wr_ok && !bus.i_clr;
    unf_d    = bus.i_rd && !rd_ok && !bus.i_clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (bus.i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + ONE;
      if (wr_ok && !rd_ok)      fill_d = fill_q + ONE;
      else if (rd_ok && !wr_ok) fill_d = fill_q - ONE;
    end
    full_d   = (fill_d == NWORDS);
    empty_d  = (fill_d == '0);
    afull_d  = (fill_d >= AFULL_TH);
    aempty_d = (fill_d <= AEMPTY_TH);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage carries no reset; only the pointers decide what is live.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem_q[wr_ptr_q[G_DEPTH-1:0]] <= bus.i_data;
  end

  assign head = mem_q[rd_ptr_q[G_DEPTH-1:0]];

  if (G_FWFT != 0) begin : g_fwft
    assign bus.o_data  = head;
    assign bus.o_valid = !empty_q;
  end else begin : g_std
    logic [G_WIDTH-1:0] data_q;
    logic               valid_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) data_q <= head;
      end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
  end

  assign bus.o_fill         = fill_q;
  assign bus.o_full         = full_q;
  assign bus.o_empty        = empty_q;
  assign bus.o_almost_full  = afull_q;
  assign bus.o_almost_empty = aempty_q;
  assign bus.o_overflow     = ovf_q;
  assign bus.o_underflow    = unf_q;
endmodule

// File: tb/tb_synchronous_fifo_flags.sv
// Bench for synchronous_fifo_flags: a standard-mode and a FWFT instance driven
// in lockstep, checked against a queue model, a read scoreboard and a vector table.
module tb_synchronous_fifo_flags;
  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  synchronous_fifo_flags_if #(.G_WIDTH(W), .G_DEPTH(D)) bus_s ();
  synchronous_fifo_flags_if #(.G_WIDTH(W), .G_DEPTH(D)) bus_f ();

  synchronous_fifo_flags #(.G_WIDTH(W), .G_DEPTH(D), .G_FWFT(0), .G_AFULL(12), .G_AEMPTY(4)) u_std (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_s));
  synchronous_fifo_flags #(.G_WIDTH(W), .G_DEPTH(D), .G_FWFT(1), .G_AFULL(12), .G_AEMPTY(4)) u_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_f));

  int n_pass = 0;
  int n_tot  = 0;
  logic [7:0] model [$];
  logic [7:0] sb [$];
  logic [7:0] last_std = 8'h00;

  typedef struct {
    bit         wr, rd, clr;
    logic [7:0] d;
    bit         inc;
    int         rep;
    int         fill;
    bit         ovf, unf;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic drive(input bit wr, input bit rd, input bit clr, input logic [7:0] d);
    bus_s.i_wr = wr; bus_s.i_rd = rd; bus_s.i_clr = clr; bus_s.i_data = d;
    bus_f.i_wr = wr; bus_f.i_rd = rd; bus_f.i_clr = clr; bus_f.i_data = d;
  endtask

  task automatic chk_reset();
    chk("rst_fill",   32'(bus_s.o_fill), 32'd0);
    chk("rst_empty",  32'(bus_s.o_empty), 32'd1);
    chk("rst_aempty", 32'(bus_s.o_almost_empty), 32'd1);
    chk("rst_full",   32'(bus_s.o_full), 32'd0);
    chk("rst_afull",  32'(bus_s.o_almost_full), 32'd0);
    chk("rst_valid",  32'(bus_s.o_valid), 32'd0);
    chk("rst_data",   32'(bus_s.o_data), 32'd0);
    chk("rst_ovf",    32'(bus_s.o_overflow), 32'd0);
    chk("rst_unf",    32'(bus_s.o_underflow), 32'd0);
    chk("rst_f_fill", 32'(bus_f.o_fill), 32'd0);
    chk("rst_f_empty",32'(bus_f.o_empty), 32'd1);
    chk("rst_f_valid",32'(bus_f.o_valid), 32'd0);
  endtask

  // One clock of stimulus; the model predicts acceptance before the edge.
  task automatic step(input bit wr, input bit rd, input bit clr, input logic [7:0] d);
    int sz;
    bit rok, wok, eovf, eunf;
    sz   = model.size();
    rok  = rd && (sz > 0) && !clr;
    wok  = wr && ((sz < N) || rok) && !clr;
    eovf = wr && !wok && !clr;
    eunf = rd && !rok && !clr;
    if (clr) model.delete();
    else begin
      if (rok) sb.push_back(model.pop_front());
      if (wok) model.push_back(d);
    end
    drive(wr, rd, clr, d);
    @(posedge clk);
    #1;
    sz = model.size();
    chk("fill",   32'(bus_s.o_fill), 32'(sz));
    chk("full",   32'(bus_s.o_full), 32'(sz == N));
    chk("empty",  32'(bus_s.o_empty), 32'(sz == 0));
    chk("afull",  32'(bus_s.o_almost_full), 32'(sz >= 12));
    chk("aempty", 32'(bus_s.o_almost_empty), 32'(sz <= 4));
    chk("ovf",    32'(bus_s.o_overflow), 32'(eovf));
    chk("unf",    32'(bus_s.o_underflow), 32'(eunf));
    chk("valid",  32'(bus_s.o_valid), 32'(rok));
    if (rok && sb.size() > 0) last_std = sb.pop_front();
    chk("data",   32'(bus_s.o_data), 32'(last_std));
    chk("f_fill", 32'(bus_f.o_fill), 32'(sz));
    chk("f_ovf",  32'(bus_f.o_overflow), 32'(eovf));
    chk("f_unf",  32'(bus_f.o_underflow), 32'(eunf));
    chk("f_valid",32'(bus_f.o_valid), 32'(sz > 0));
    if (sz > 0) chk("f_data", 32'(bus_f.o_data), 32'(model[0]));
  endtask

  task automatic add(input bit wr, input bit rd, input bit clr, input logic [7:0] d,
                     input bit inc, input int rep, input int fill, input bit ovf, input bit unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.d = d; v.inc = inc; v.rep = rep;
    v.fill = fill; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #12;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;

    //  wr    rd    clr   data   inc  rep fill ovf unf
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16, 16, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16,  0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16, 16, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'hAA, 1'b0,  1, 16, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0,  1, 16, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'h55, 1'b0,  1, 16, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16,  0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0,  1,  0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0,  1,  0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'h33, 1'b0,  1,  1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0,  1,  0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'h40, 1'b1,  5,  5, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'h99, 1'b0,  1,  0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0,  1,  0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 8'h11, 1'b0,  1,  1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'h22, 1'b0,  1,  2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0,  1,  1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0,  1,  0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'hC0, 1'b1,  3,  3, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 40,  3, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].rep; r++)
        step(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].inc ? tbl[i].d + 8'(r) : tbl[i].d);
      chk($sformatf("row%0d_fill", i), 32'(bus_s.o_fill), 32'(tbl[i].fill));
      chk($sformatf("row%0d_ovf", i),  32'(bus_s.o_overflow), 32'(tbl[i].ovf));
      chk($sformatf("row%0d_unf", i),  32'(bus_s.o_underflow), 32'(tbl[i].unf));
    end

    // Asynchronous reset between edges while a write/read pair is pending.
    drive(1'b1, 1'b1, 1'b0, 8'hEE);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset();
    model.delete();
    sb.delete();
    last_std = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h77);
    chk("post_rst_fill", 32'(bus_s.o_fill), 32'd1);
    chk("post_rst_f_data", 32'(bus_f.o_data), 32'h77);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_rst_data", 32'(bus_s.o_data), 32'h77);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/synchronous_fifo_flags.md
Name: synchronous_fifo_flags

Overview:
- Single-clock FIFO, parametrised in width, depth and read mode (standard registered-read or first-word-fall-through).
- Adds a registered fill level, programmable almost-full/almost-empty thresholds, a synchronous flush, and registered overflow/underflow pulses.
- Simultaneous read and write are accepted at the full boundary.
- Drop-in buffer between single-clock producer/consumer pipelines where the dual-clock FIFO is unnecessary.

Parameters:
- G_WIDTH, 8: data word width in bits.
- G_DEPTH, 4: log2 of entry count (2**G_DEPTH entries, 16 by default).
- G_FWFT, 0: 0 = standard mode (data on o_data the cycle after a read); 1 = first-word-fall-through (head word always presented).
- G_AFULL, 12: o_almost_full asserted when fill >= G_AFULL. Legal range 1..2**G_DEPTH.
- G_AEMPTY, 4: o_almost_empty asserted when fill <= G_AEMPTY. Legal range 0..2**G_DEPTH-1.

Ports:
- i_clk  in  1  single clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clr  in  1  synchronous flush, active high.
- i_wr  in  1  write request.
- i_data  in  G_WIDTH  write data.
- i_rd  in  1  read request (in FWFT mode: pop acknowledge).
- o_data  out  G_WIDTH  read data.
- o_valid  out  1  o_data holds a newly read word.
- o_full  out  1  fill == 2**G_DEPTH.
- o_empty  out  1  fill == 0.
- o_almost_full  out  1  fill >= G_AFULL.
- o_almost_empty  out  1  fill <= G_AEMPTY.
- o_fill  out  G_DEPTH+1  current entry count.
- o_overflow  out  1  one-cycle pulse: a write was rejected.
- o_underflow  out  1  one-cycle pulse: a read was rejected.

Behaviour:
- Reset (i_rst_n low, asynchronous, takes effect immediately):
  - Pointers, o_fill, o_data, o_valid, o_full, o_almost_full, o_overflow and o_underflow go to 0.
  - o_empty and o_almost_empty go to 1.
  - Memory contents are not reset.
- Pointers are G_DEPTH+1 bits wide and wrap modulo 2**(G_DEPTH+1). Memory is indexed by the low G_DEPTH bits.
- o_fill is a registered up/down counter, not derived from pointer subtraction. All flags are registered, computed from the next-state fill, so they are valid in the same cycle as o_fill.
- Read accept: rd_ok = i_rd && !o_empty.
- Write accept: wr_ok = i_wr && (!o_full || rd_ok).
  - When full, a simultaneous read frees a slot, so both are accepted and fill stays at 2**G_DEPTH.
- When empty, i_rd+i_wr together: the write is accepted, the read is rejected (underflow pulse), and fill becomes 1.
- Fill update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Standard mode (G_FWFT=0):
  - On rd_ok, o_data <= mem[rd_ptr] at the edge and o_valid pulses high for exactly one cycle.
  - o_data holds its value otherwise. Read latency is 1 cycle.
- FWFT mode (G_FWFT=1):
  - o_data = mem[rd_ptr] combinationally and o_valid = !o_empty.
  - A write into an empty FIFO is visible on o_data the cycle after the write edge.
  - i_rd with o_valid=1 pops the word at the edge.
- o_overflow: registered, high for one cycle after any edge where i_wr && !wr_ok.
- o_underflow: registered, high for one cycle after any edge where i_rd && !rd_ok.
- i_clr:
  - Overrides i_wr and i_rd in the same cycle.
  - Next edge: pointers and fill go to 0, o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0, o_valid=0.
  - No overflow or underflow pulse is generated.
  - o_data keeps its last value in standard mode.
- Reset asserted mid-burst: outputs change immediately and in-flight data is discarded. First accepted write after reset release goes to address 0.
- Pointer wrap: after 2**(G_DEPTH+1) writes/reads the pointers return to 0 with no effect on data order or flags.

Test Plan (G_WIDTH=8, G_DEPTH=4, G_AFULL=12, G_AEMPTY=4):
- Standard mode fill/drain: write 0x00..0x0F on 16 consecutive cycles → o_fill reaches 16, o_full=1, o_almost_full=1 from fill 12. Then 16 reads → o_data 0x00..0x0F one cycle after each read, o_valid pulsing, o_empty=1 at the end.
- Overflow/underflow: when full, i_wr alone with 0xAA → o_overflow pulses once and fill stays 16. When empty, i_rd alone → o_underflow pulses once, o_valid stays 0, fill stays 0.
- Full boundary: at fill 16, i_wr=1 (0x55) with i_rd=1 → fill stays 16, no overflow, 0x55 read out last after draining. When empty, i_wr=1 (0x33) with i_rd=1 → fill becomes 1, o_underflow pulses, next read returns 0x33.
- FWFT (G_FWFT=1): write 0x11 into empty → o_valid=1 and o_data=0x11 the next cycle. Write 0x22 then pulse i_rd → o_data=0x22 and fill=1.
- Flush and threshold: fill to 5 (o_almost_empty=0), then assert i_clr together with i_wr → next cycle fill=0, o_empty=1, o_almost_empty=1, no overflow pulse, written word discarded.
- Async reset plus wrap: run 40 write/read pairs (pointers wrap) with data checked in order. Deassert i_rst_n mid-stream without a clock edge → outputs reset immediately. First post-reset write/read returns the new data correctly.
